// File: rtl/wm_fill_arbiter.sv
// Round-robin arbiter sharing one water-inlet valve among NUM_WM washer controllers,
// with a per-grant fill watchdog and a valve-fault lockout.
//   state   | meaning
//   IDLE    | valve closed, arbitrating requests
//   GRANT   | one machine owns the open valve, watchdog running
//   RELEASE | one-cycle valve-close guard between owners
//   FAULT   | plumbing fault, valve forced closed, requests ignored
module wm_fill_arbiter #(
    parameter int NUM_WM       = 4,
    parameter int ID_W         = 2,
    parameter int TMO_W        = 16,
    parameter int MAX_FILL_CYC = 1000
) (
    input  logic              WMFA_CLK,
    input  logic              WMFA_RST,
    input  logic [NUM_WM-1:0] WMFA_req,
    input  logic [NUM_WM-1:0] WMFA_done,
    input  logic              WMFA_valve_fault,
    input  logic              WMFA_timeout_clr,
    output logic [NUM_WM-1:0] WMFA_gnt,
    output logic [ID_W-1:0]   WMFA_gnt_id,
    output logic              WMFA_valve_open,
    output logic              WMFA_busy,
    output logic              WMFA_timeout,
    output logic [ID_W-1:0]   WMFA_timeout_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b11,
        ST_FAULT   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_WM-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   tmo_id_q, tmo_id_d;
    logic              valve_q, valve_d;
    logic              busy_q, busy_d;
    logic              tmo_q, tmo_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    int                rr_idx;
    logic              owner_done, owner_req, expire;

    // gnt_q is one-hot while in GRANT, so it doubles as the owner select
    assign owner_done = |(WMFA_done & gnt_q);
    assign owner_req  = |(WMFA_req & gnt_q);
    assign expire     = (wdog_q == TMO_W'(MAX_FILL_CYC - 1));

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        rr_idx  = 0;
        for (int i = 1; i <= NUM_WM; i++) begin
            rr_idx = (int'(ptr_q) + i) % NUM_WM;
            for (int j = 0; j < NUM_WM; j++) begin
                if (!win_vld && (j == rr_idx) && WMFA_req[j]) begin
                    win_vld = 1'b1;
                    win_id  = ID_W'(j);
                end
            end
        end
    end

    always_ff @(posedge WMFA_CLK or negedge WMFA_RST) begin
        if (!WMFA_RST) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= ID_W'(NUM_WM - 1);
            tmo_id_q <= '0;
            valve_q  <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            tmo_id_q <= tmo_id_d;
            valve_q  <= valve_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
            wdog_q   <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (WMFA_valve_fault)  state_d = ST_FAULT;
                else if (win_vld)      state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (WMFA_valve_fault)                       state_d = ST_FAULT;
                else if (owner_done || !owner_req || expire) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = WMFA_valve_fault ? ST_FAULT : ST_IDLE;
            ST_FAULT: begin
                if (!WMFA_valve_fault) state_d = ST_RELEASE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = '0;
        valve_d  = 1'b0;
        wdog_d   = '0;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        tmo_d    = tmo_q & ~WMFA_timeout_clr;
        tmo_id_d = tmo_id_q;
        busy_d   = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (state_d == ST_GRANT) begin
                    gnt_d    = NUM_WM'(1) << win_id;
                    gnt_id_d = win_id;
                    ptr_d    = win_id;
                    valve_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (state_d == ST_GRANT) begin
                    gnt_d   = gnt_q;
                    valve_d = 1'b1;
                    wdog_d  = wdog_q + TMO_W'(1);
                end
                // done on the expiry cycle wins; only a pure watchdog release flags
                if (!WMFA_valve_fault && !owner_done && owner_req && expire) begin
                    tmo_d    = 1'b1;
                    tmo_id_d = gnt_id_q;
                end
            end
            default: ;
        endcase
    end

    assign WMFA_gnt        = gnt_q;
    assign WMFA_gnt_id     = gnt_id_q;
    assign WMFA_valve_open = valve_q;
    assign WMFA_busy       = busy_q;
    assign WMFA_timeout    = tmo_q;
    assign WMFA_timeout_id = tmo_id_q;

endmodule

// File: tb/tb_wm_fill_arbiter.sv
// Scoreboard bench for wm_fill_arbiter: expected winners queued at stimulus time,
// popped when a new grant appears; directed checks for release, timeout and fault paths.
module tb_wm_fill_arbiter;

    localparam int NUM_WM   = 4;
    localparam int ID_W     = 2;
    localparam int TMO_W    = 16;
    localparam int MAX_FILL = 8;

    logic              clk_sys = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NUM_WM-1:0] req     = '0;
    logic [NUM_WM-1:0] done    = '0;
    logic              fault   = 1'b0;
    logic              clr     = 1'b0;
    logic [NUM_WM-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              valve;
    logic              busy;
    logic              tmo;
    logic [ID_W-1:0]   tmo_id;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic [NUM_WM-1:0] prev_gnt = '0;

    wm_fill_arbiter #(
        .NUM_WM       (NUM_WM),
        .ID_W         (ID_W),
        .TMO_W        (TMO_W),
        .MAX_FILL_CYC (MAX_FILL)
    ) dut (
        .WMFA_CLK         (clk_sys),
        .WMFA_RST         (rst_n),
        .WMFA_req         (req),
        .WMFA_done        (done),
        .WMFA_valve_fault (fault),
        .WMFA_timeout_clr (clr),
        .WMFA_gnt         (gnt),
        .WMFA_gnt_id      (gnt_id),
        .WMFA_valve_open  (valve),
        .WMFA_busy        (busy),
        .WMFA_timeout     (tmo),
        .WMFA_timeout_id  (tmo_id)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic wait_gnt(output int gap);
        gap = 0;
        while (gnt == '0 && gap < 30) begin
            gap++;
            step();
        end
        chk("gnt_arrived", 32'(gnt != '0), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},    32'(gnt),    32'd0);
        chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
        chk({tag, "_valve"},  32'(valve),  32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_tmo"},    32'(tmo),    32'd0);
        chk({tag, "_tmo_id"}, 32'(tmo_id), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        fault = 1'b0;
        clr   = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        rst_n = 1'b1;
    endtask

    // Scoreboard and invariant monitor
    always @(negedge clk_sys) begin
        int e;
        chk("valve_vs_gnt", 32'(valve), 32'(|gnt));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (prev_gnt == '0 && gnt != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_gnt_id", 32'(gnt_id), 32'(e));
                chk("sb_gnt_vec", 32'(gnt), 32'd1 << e);
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    initial begin
        int gap;
        int hi;
        int id;

        do_reset();

        // single request, done, release gap
        req = 4'b0001;
        exp_q.push_back(0);
        step();
        chk("t1_gnt",    32'(gnt),    32'h1);
        chk("t1_gnt_id", 32'(gnt_id), 32'd0);
        chk("t1_valve",  32'(valve),  32'd1);
        chk("t1_busy",   32'(busy),   32'd1);
        done = 4'b0001;
        step();
        done = '0;
        req  = '0;
        chk("t1_rel_valve", 32'(valve), 32'd0);
        chk("t1_rel_busy",  32'(busy),  32'd1);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // round robin with all requesting
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            id = n % NUM_WM;
            exp_q.push_back(id);
            wait_gnt(gap);
            if (n > 0) chk("t2_gap", 32'(gap), 32'd2);
            repeat (4) step();
            done = 4'(1 << id);
            step();
            done = '0;
        end
        req = '0;
        step();
        step();

        // watchdog expiry
        req = 4'b0100;
        exp_q.push_back(2);
        wait_gnt(gap);
        hi = 1;
        while (gnt != '0 && hi < 40) begin
            step();
            if (gnt != '0) hi++;
        end
        chk("t3_gnt_len", 32'(hi),     32'(MAX_FILL));
        chk("t3_tmo",     32'(tmo),    32'd1);
        chk("t3_tmo_id",  32'(tmo_id), 32'd2);
        req = '0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t3_clr", 32'(tmo), 32'd0);
        step();

        // non-owner done ignored; done coincident with expiry wins
        req = 4'b0010;
        exp_q.push_back(1);
        wait_gnt(gap);
        repeat (2) step();
        done = 4'b1000;
        step();
        done = '0;
        chk("t4_nonowner_done", 32'(gnt), 32'h2);
        repeat (4) step();
        chk("t4_still_gnt", 32'(gnt), 32'h2);
        done = 4'b0010;
        step();
        done = '0;
        req  = '0;
        chk("t4_rel_gnt",   32'(gnt),   32'd0);
        chk("t4_rel_valve", 32'(valve), 32'd0);
        chk("t4_no_tmo",    32'(tmo),   32'd0);
        step();

        // fault during grant, re-arbitration from the interrupted owner
        req = 4'b0100;
        exp_q.push_back(2);
        wait_gnt(gap);
        fault = 1'b1;
        req   = 4'b0101;
        step();
        chk("t5_fault_gnt",   32'(gnt),   32'd0);
        chk("t5_fault_valve", 32'(valve), 32'd0);
        chk("t5_fault_busy",  32'(busy),  32'd1);
        repeat (9) begin
            step();
            chk("t5_fault_hold", 32'(valve), 32'd0);
        end
        fault = 1'b0;
        exp_q.push_back(0);
        wait_gnt(gap);
        chk("t5_gap", 32'(gap), 32'd3);
        chk("t5_tmo", 32'(tmo), 32'd0);
        req = '0;
        step();
        chk("t5_abandon", 32'(gnt), 32'd0);
        step();

        // abandoned request, then async reset mid-grant
        req = 4'b0010;
        exp_q.push_back(1);
        wait_gnt(gap);
        repeat (2) step();
        req = '0;
        step();
        chk("t6_drop_gnt",   32'(gnt),   32'd0);
        chk("t6_drop_valve", 32'(valve), 32'd0);
        step();
        req = 4'b0100;
        exp_q.push_back(2);
        wait_gnt(gap);
        step();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_async");
        req = 4'b1001;
        step();
        rst_n = 1'b1;
        exp_q.push_back(0);
        wait_gnt(gap);
        req = '0;
        step();
        step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wm_fill_arbiter.md
Name: wm_fill_arbiter

Overview:
- Shares the single water-inlet valve among NUM_WM washing-machine controllers. Only one machine may be in its Filing_Water phase with the valve open at a time.
- Each machine raises a fill request; the arbiter grants one at a time in round-robin order and drives the valve.
- A watchdog releases any grant that is held too long, and a valve-fault input forces the valve closed.
- Sits between the per-machine controllers and the physical valve driver.

Parameters:
- NUM_WM, 4, number of requesting machines (2..2**ID_W).
- ID_W, 2, width of machine index outputs.
- TMO_W, 16, width of the fill watchdog counter.
- MAX_FILL_CYC, 1000, maximum grant length in clock cycles before forced release (1..2**TMO_W-1).

Ports:
- WMFA_CLK  input  1  system clock, rising edge.
- WMFA_RST  input  1  asynchronous active-low reset.
- WMFA_req  input  NUM_WM  level request per machine; held while that machine wants water.
- WMFA_done  input  NUM_WM  one-cycle pulse from a machine when its fill completes.
- WMFA_valve_fault  input  1  level; valve/pressure fault from the plumbing sensor.
- WMFA_timeout_clr  input  1  pulse; clears the sticky timeout flag.
- WMFA_gnt  output  NUM_WM  one-hot grant, all-zero when no owner.
- WMFA_gnt_id  output  ID_W  index of the current or last owner.
- WMFA_valve_open  output  1  valve drive.
- WMFA_busy  output  1  high in any state other than IDLE.
- WMFA_timeout  output  1  sticky watchdog flag.
- WMFA_timeout_id  output  ID_W  owner index at the last timeout.

Behaviour:
- One clock; reset is asynchronous and active-low (WMFA_RST). All outputs and state are registered.
- Reset values: gnt=0, gnt_id=0, valve_open=0, busy=0, timeout=0, timeout_id=0, state=IDLE, round-robin pointer=NUM_WM-1 (so index 0 has highest priority first), watchdog=0.
- States (gray encoded): IDLE=2'b00, GRANT=2'b01, RELEASE=2'b11, FAULT=2'b10.
- IDLE:
  - valve_fault=1 -> FAULT.
  - Otherwise, if any req bit is high -> GRANT on the next edge.
  - Winner = first set req bit searching upward from pointer+1, wrapping modulo NUM_WM.
  - On that edge: gnt=onehot(winner), gnt_id=winner, valve_open=1, pointer=winner, watchdog=0.
  - Latency: req sampled at edge k gives gnt and valve_open high after edge k.
- GRANT: watchdog increments every cycle. Exit conditions, highest priority first:
  - valve_fault=1 -> FAULT.
  - done[owner]=1 -> RELEASE.
  - req[owner]=0 (abandoned) -> RELEASE.
  - watchdog==MAX_FILL_CYC-1 -> RELEASE; set timeout=1, timeout_id=owner.
- done from a non-owner is ignored in every state. A done and the watchdog expiry in the same cycle count as done: no timeout flag.
- RELEASE:
  - Lasts exactly one cycle: gnt=0, valve_open=0 (valve-close guard), gnt_id holds.
  - Next state is IDLE, or FAULT if valve_fault=1.
  - No back-to-back grant without this gap. Minimum spacing between grants is 2 cycles (RELEASE + IDLE).
- FAULT:
  - gnt=0 and valve_open=0 from the edge after entry; requests are ignored.
  - Stays while valve_fault=1; on fault deassert -> RELEASE -> IDLE.
  - The pointer is unchanged, so an interrupted owner is re-arbitrated fairly and gets no re-grant priority.
- Fault interrupting a grant neither clears nor sets timeout.
- timeout_clr clears timeout on the next edge. A set in the same cycle wins over the clear.
- Reset mid-grant closes the valve immediately (asynchronously) and returns to IDLE with the pointer reset.
- Invariants: gnt is at most one-hot; valve_open == |gnt at all times.

Test Plan:
- Reset, then req=4'b0001 at edge 1 -> gnt=0001, gnt_id=0, valve_open=1 after edge 1; done[0] pulse -> one RELEASE cycle (valve_open=0), then IDLE with busy=0.
- req=4'b1111 held, each owner pulses done 5 cycles after its grant -> grant order 0,1,2,3,0 with exactly 2 cycles of gnt=0 between consecutive grants.
- MAX_FILL_CYC=8, req=4'b0100 held with no done -> gnt high exactly 8 cycles, then release; timeout=1, timeout_id=2; timeout_clr pulse -> timeout=0.
- Owner 1 granted, done[3] pulse, then done[1] and watchdog expiry in the same cycle -> done[3] ignored; release with timeout still 0.
- Owner 2 granted, valve_fault=1 for 10 cycles -> gnt=0 and valve_open=0 from the next edge through the fault; after deassert, one RELEASE cycle, then re-arbitration from pointer 2 (req=4'b0101 grants index 0).
- req=4'b0010 dropped mid-grant -> release within 1 cycle; WMFA_RST pulsed low during a later grant -> valve_open=0 immediately and all outputs at reset values.
